nn_layer_sequencer: RTL and testbench

//  Parametrised top-level sequencer for the neural-network datapath. Runs a batch of
//  run-time-selectable length through NUM_HIDDEN hidden layers plus one output stage.

---
 rtl/nn_layer_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
//==============================================================================
// Module      : nn_layer_sequencer
// Description : Batch sequencer stepping each sample through NUM_HIDDEN hidden
//               layers and one output stage, handshaking on calc_done.
//               Optional stage watchdog enabled by defining NNSEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module nn_layer_sequencer #(
  parameter int NUM_HIDDEN     = 2,
  parameter int SAMPLE_W       = 10,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int LAYER_W       = (NUM_HIDDEN > 1) ? $clog2(NUM_HIDDEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SAMPLE_W-1:0]   num_samples,
  input  logic                  calc_done,
  output logic                  hidden,
  output logic [NUM_HIDDEN-1:0] ld,
  output logic                  out_ld,
  output logic [LAYER_W-1:0]    layer_idx,
  output logic [SAMPLE_W-1:0]   sample_idx,
  output logic                  batch_done,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HIDDEN = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  localparam logic [LAYER_W-1:0]    c_last_layer = LAYER_W'(NUM_HIDDEN - 1);
  localparam logic [NUM_HIDDEN-1:0] c_ld_one     = NUM_HIDDEN'(1);

  if (NUM_HIDDEN < 1 || SAMPLE_W < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("nn_layer_sequencer: illegal parameter combination");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LAYER_W-1:0]  r_layer_idx;
  logic [LAYER_W-1:0]  w_layer_nxt;
  logic [SAMPLE_W-1:0] r_sample_idx;
  logic [SAMPLE_W-1:0] w_sample_nxt;
  logic [SAMPLE_W-1:0] r_count;
  logic [SAMPLE_W-1:0] w_count_nxt;

`ifdef NNSEQ_TIMEOUT_EN
  localparam int               c_wait_w    = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT_CYCLES - 1);

  logic [c_wait_w-1:0] r_wait;
  logic                r_err;
  logic                w_err_nxt;
  logic                w_wait_expired;
  logic                w_stage_entry;

  assign w_wait_expired = (r_wait == c_wait_last) && !calc_done;
  assign w_stage_entry  = ((w_state_nxt == S_HIDDEN) && (r_state != S_HIDDEN)) ||
                          ((w_state_nxt == S_OUTPUT) && (r_state != S_OUTPUT));

  // Counts cycles spent waiting in the current stage; restarts per stage and per calc_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
      if (w_stage_entry || calc_done) begin
        r_wait <= '0;
      end else if (hidden || out_ld) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_layer_idx  <= '0;
      r_sample_idx <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_layer_idx  <= w_layer_nxt;
      r_sample_idx <= w_sample_nxt;
      r_count      <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_layer_nxt  = r_layer_idx;
    w_sample_nxt = r_sample_idx;
    w_count_nxt  = r_count;
`ifdef NNSEQ_TIMEOUT_EN
    w_err_nxt    = r_err;
`endif
    hidden       = 1'b0;
    out_ld       = 1'b0;
    done         = 1'b0;
    batch_done   = 1'b0;
    ld           = '0;

    case (r_state)
      S_IDLE: begin
        done = 1'b1;
        if (start) begin
          w_count_nxt  = num_samples;
          w_sample_nxt = '0;
`ifdef NNSEQ_TIMEOUT_EN
          w_err_nxt    = 1'b0;
`endif
          w_state_nxt  = S_FETCH;
        end
      end

      // Compare before any increment: sample_idx can never pass count, so it never wraps.
      S_FETCH: begin
        if (r_sample_idx == r_count) begin
          w_state_nxt = S_IDLE;
        end else begin
          batch_done  = 1'b1;
          w_layer_nxt = '0;
          w_state_nxt = S_HIDDEN;
        end
      end

      S_HIDDEN: begin
        hidden = 1'b1;
        ld     = c_ld_one << r_layer_idx;
        if (calc_done) begin
          if (r_layer_idx == c_last_layer) begin
            w_state_nxt = S_OUTPUT;
          end else begin
            w_layer_nxt = r_layer_idx + 1'b1;
          end
        end
`ifdef NNSEQ_TIMEOUT_EN
        else if (w_wait_expired) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end

      S_OUTPUT: begin
        out_ld = 1'b1;
        if (calc_done) begin
          w_sample_nxt = r_sample_idx + 1'b1;
          w_state_nxt  = S_FETCH;
        end
`ifdef NNSEQ_TIMEOUT_EN
        else if (w_wait_expired) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign layer_idx  = r_layer_idx;
  assign sample_idx = r_sample_idx;

endmodule

`default_nettype wire

// File: tb/tb_nn_layer_sequencer.sv
//==============================================================================
// Module      : tb_nn_layer_sequencer
// Description : Randomised self-checking bench for nn_layer_sequencer against a
//               per-cycle expected trace built from the batch/stage rules.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_nn_layer_sequencer;

  localparam int NH  = 2;
  localparam int SW  = 10;
  localparam int TMO = 8;
  localparam int LW  = (NH > 1) ? $clog2(NH) : 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] num_samples = '0;
  logic          calc_done = 1'b0;
  logic          hidden;
  logic [NH-1:0] ld;
  logic          out_ld;
  logic [LW-1:0] layer_idx;
  logic [SW-1:0] sample_idx;
  logic          batch_done;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nn_layer_sequencer #(
    .NUM_HIDDEN    (NH),
    .SAMPLE_W      (SW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_samples(num_samples),
    .calc_done  (calc_done),
    .hidden     (hidden),
    .ld         (ld),
    .out_ld     (out_ld),
    .layer_idx  (layer_idx),
    .sample_idx (sample_idx),
    .batch_done (batch_done),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    bit            done;
    bit            hid;
    bit            oload;
    bit            bd;
    logic [NH-1:0] ld;
    int            layer;
    int            sample;
  } exp_t;

  exp_t q[$];
  bit   cdq[$];

  function automatic exp_t mk(bit dn, bit hid, bit ol, bit bd, int layer, int sample);
    exp_t e;
    e.done   = dn;
    e.hid    = hid;
    e.oload  = ol;
    e.bd     = bd;
    e.layer  = layer;
    e.sample = sample;
    e.ld     = hid ? NH'(1 << layer) : '0;
    return e;
  endfunction

  // Expected per-cycle outputs after accept, with the calc_done to drive in that cycle.
  task automatic build(int n, int mind, int maxd);
    int d;
    q.delete();
    cdq.delete();
    for (int s = 0; s < n; s++) begin
      q.push_back(mk(0, 0, 0, 1, 0, s));
      cdq.push_back(1'($urandom));
      for (int st = 0; st <= NH; st++) begin
        d = $urandom_range(maxd, mind);
        for (int k = 0; k < d; k++) begin
          q.push_back((st < NH) ? mk(0, 1, 0, 0, st, s) : mk(0, 0, 1, 0, 0, s));
          cdq.push_back(k == d - 1);
        end
      end
    end
    q.push_back(mk(0, 0, 0, 0, 0, n));
    cdq.push_back(1'($urandom));
    q.push_back(mk(1, 0, 0, 0, 0, n));
    cdq.push_back(1'($urandom));
  endtask

  task automatic run_batch(string name, int n, int mind, int maxd, bit hold, bit scramble);
    build(n, mind, maxd);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_before_accept done=%b expected=1", name, done);
    end
    start       = 1'b1;
    num_samples = SW'(n);
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      if (!hold || k == q.size() - 1) start = 1'b0;
      if (scramble) num_samples = SW'($urandom_range(15, 0));
      checks++;
      if ({done, hidden, out_ld, batch_done, ld, sample_idx, err} !==
          {q[k].done, q[k].hid, q[k].oload, q[k].bd, q[k].ld, SW'(q[k].sample), 1'b0}) begin
        errors++;
        $display("FAIL %s cycle %0d got done=%b hid=%b out_ld=%b bd=%b ld=%b smp=%0d err=%b expected done=%b hid=%b out_ld=%b bd=%b ld=%b smp=%0d err=0",
                 name, k, done, hidden, out_ld, batch_done, ld, sample_idx, err,
                 q[k].done, q[k].hid, q[k].oload, q[k].bd, q[k].ld, q[k].sample);
      end
      if (q[k].hid) begin
        checks++;
        if (layer_idx !== LW'(q[k].layer)) begin
          errors++;
          $display("FAIL %s cycle %0d layer_idx got %0d expected %0d", name, k, layer_idx, q[k].layer);
        end
      end
      calc_done = cdq[k];
    end
    calc_done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({done, hidden, ld, out_ld, batch_done, layer_idx, sample_idx, err} !==
        {1'b1, 1'b0, NH'(0), 1'b0, 1'b0, LW'(0), SW'(0), 1'b0}) begin
      errors++;
      $display("FAIL reset_state got done=%b hid=%b ld=%b out_ld=%b bd=%b layer=%0d smp=%0d err=%b expected done=1 rest 0",
               done, hidden, ld, out_ld, batch_done, layer_idx, sample_idx, err);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || hidden !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start got done=%b hid=%b expected done=1 hid=0", done, hidden);
    end
  endtask

  task automatic test_basic;
    run_batch("basic_n3", 3, 1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_empty;
    run_batch("empty_n0", 0, 1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_delayed;
    run_batch("delay5", 2, 5, 5, 1'b0, 1'b0);
  endtask

  task automatic test_hold_start;
    run_batch("hold_start", 3, 1, 3, 1'b1, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      run_batch("random", $urandom_range(5, 0), 1, 6, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start       = 1'b1;
    num_samples = SW'(3);
    calc_done   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if ({hidden, ld, layer_idx, sample_idx} !== {1'b1, NH'(2), LW'(1), SW'(1)}) begin
      errors++;
      $display("FAIL pre_reset_pos got hid=%b ld=%b layer=%0d smp=%0d expected hid=1 ld=10 layer=1 smp=1",
               hidden, ld, layer_idx, sample_idx);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({done, hidden, ld, out_ld, sample_idx} !== {1'b1, 1'b0, NH'(0), 1'b0, SW'(0)}) begin
      errors++;
      $display("FAIL async_reset got done=%b hid=%b ld=%b out_ld=%b smp=%0d expected done=1 hid=0 ld=00 out_ld=0 smp=0",
               done, hidden, ld, out_ld, sample_idx);
    end
    calc_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_idle done=%b expected 1", done);
    end
  endtask

  task automatic test_watchdog;
    @(negedge clk);
    start       = 1'b1;
    num_samples = SW'(2);
    calc_done   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (hidden !== 1'b1 || ld !== NH'(1)) begin
      errors++;
      $display("FAIL stall_entry got hid=%b ld=%b expected hid=1 ld=01", hidden, ld);
    end
`ifdef NNSEQ_TIMEOUT_EN
    repeat (TMO - 1) @(negedge clk);
    checks++;
    if (hidden !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_before got hid=%b err=%b expected hid=1 err=0", hidden, err);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_fire got done=%b err=%b expected done=1 err=1", done, err);
    end
    start       = 1'b1;
    num_samples = SW'(0);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clear got done=%b err=%b expected done=0 err=0", done, err);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_idle got done=%b err=%b expected done=1 err=0", done, err);
    end
`else
    repeat (20) @(negedge clk);
    checks++;
    if (hidden !== 1'b1 || ld !== NH'(1) || err !== 1'b0) begin
      errors++;
      $display("FAIL stall_wait got hid=%b ld=%b err=%b expected hid=1 ld=01 err=0", hidden, ld, err);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_empty;
    test_delayed;
    test_hold_start;
    test_random;
    test_reset_mid;
    test_watchdog;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
